// File: rtl/dm_ram_pipe_if.sv
// dm_ram_pipe_if: request/response bus of the data-memory RAM
interface dm_ram_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic                  ena;
  logic [DATA_W/8-1:0]   wea;
  logic [ADDR_W-1:0]     addra;
  logic [DATA_W-1:0]     dina;
  logic [DATA_W-1:0]     douta;
  logic                  dvalid;
  logic                  err;
  logic                  busy;
  modport master (output ena, wea, addra, dina, input douta, dvalid, err, busy);
  modport slave  (input ena, wea, addra, dina, output douta, dvalid, err, busy);
endinterface

// File: rtl/dm_ram_pipe.sv
// dm_ram_pipe: byte-enable data RAM with zero-fill after reset and a 1/2-cycle read pipeline
module dm_ram_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 3072,
  parameter int RD_LAT     = 1,
  parameter int WRITE_MODE = 0
) (
  input logic          clka,
  input logic          rsta,
  dm_ram_pipe_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              busy_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd, merged, res, d1;
  logic              acc, oor, v1, e1;
  assign acc = bus.ena && !busy_q && !rsta;
  assign oor = {1'b0, bus.addra} >= LIM;
  assign rd  = oor ? '0 : mem[bus.addra];
  assign res = oor ? '0 : (WRITE_MODE != 0 ? merged : rd);
  always_comb begin
    merged = rd;
    for (int i = 0; i < NB; i++)
      if (bus.wea[i]) merged[8*i +: 8] = bus.dina[8*i +: 8];
  end
  // the zero-fill sweep and normal writes share the single write port
  always_ff @(posedge clka)
    if (!rsta) begin
      if (busy_q) mem[cnt] <= '0;
      else if (acc && !oor) mem[bus.addra] <= merged;
    end
  always_ff @(posedge clka)
    if (rsta) begin
      state  <= CLEAR;
      cnt    <= '0;
      busy_q <= 1'b1;
      v1     <= 1'b0;
      e1     <= 1'b0;
      d1     <= '0;
    end else begin
      v1 <= acc;
      e1 <= acc && oor;
      if (acc) d1 <= res;
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state  <= RUN;
          busy_q <= 1'b0;
        end
      end
    end
  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] d2;
    logic              v2, e2;
    always_ff @(posedge clka)
      if (rsta) begin
        d2 <= '0;
        v2 <= 1'b0;
        e2 <= 1'b0;
      end else begin
        v2 <= v1;
        e2 <= e1;
        if (v1) d2 <= d1;
      end
    assign bus.douta  = d2;
    assign bus.dvalid = v2;
    assign bus.err    = e2;
  end else begin : g_lat1
    assign bus.douta  = d1;
    assign bus.dvalid = v1;
    assign bus.err    = e1;
  end
  assign bus.busy = busy_q;
endmodule

// File: doc/dm_ram_pipe.md
Name: dm_ram_pipe

Overview:
Parametrised data-memory RAM for the pipelined CPU's MEM stage and the simulation harness. It is the next generation of the fixed 3072x32 data RAM, and adds:
- arbitrary per-byte write enables
- selectable read-during-write mode
- 1- or 2-cycle read latency with a valid strobe
- out-of-range error reporting
- a hardware zero-fill state machine after reset

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8; NB = DATA_W/8 byte lanes
ADDR_W, 12, word-address width
DEPTH, 3072, number of words; must satisfy DEPTH <= 2^ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2
WRITE_MODE, 0, read-during-write mode: 0 = read-first (old data), 1 = write-first (merged new data)

Ports:
clka  in  1  clock; all logic on rising edge
rsta  in  1  synchronous reset, active-high
ena  in  1  access request; accepted only when busy=0
wea  in  NB  byte-lane write enables; any bit pattern is legal; all-zero means read
addra  in  ADDR_W  word address
dina  in  DATA_W  lane-aligned write data; lane i is dina[8i+7:8i]
douta  out  DATA_W  read data
dvalid  out  1  pulses high exactly when douta holds an accepted access's result
err  out  1  out-of-range flag, aligned with dvalid
busy  out  1  high while zero-fill is in progress; requests are ignored

Behaviour:
Interface:
- One clock (clka). Reset rsta is synchronous and active-high.
- While rsta=1: douta=0, dvalid=0, err=0, busy=1, FSM=CLEAR, clear counter=0, read pipeline flushed.

FSM states:
- CLEAR: each cycle writes 0 to word[cnt], then cnt++.
  - When cnt==DEPTH-1 is written, go to RUN on the next edge; busy falls on that same edge.
  - Fill takes exactly DEPTH cycles after rsta deasserts.
- RUN: serve accesses. Only rsta returns the FSM to CLEAR.

Reset mid-operation:
- rsta during CLEAR restarts cnt at 0.
- rsta during RUN discards in-flight reads; no dvalid is produced for them.

Access rules:
- A request is accepted when ena=1, busy=0, rsta=0.
- Every accepted access, read or write, returns the addressed word on douta with dvalid=1.
- Write: each lane i with wea[i]=1 takes dina lane i; other lanes keep their value. Written on the accept edge.
- Returned data for an access that writes:
  - WRITE_MODE=0: pre-write word.
  - WRITE_MODE=1: post-merge word.
- Reads (wea=0) return the stored word.

Latency:
- RD_LAT=1: douta/dvalid/err are registered on the accept edge (visible the cycle after the request).
- RD_LAT=2: one extra output register stage.
- The pipeline never stalls. Back-to-back accepts yield back-to-back dvalid.
- A non-accepted cycle yields dvalid=0, and douta holds its last value.

Out of range:
- An address >= DEPTH suppresses the write.
- The result is douta=0, err=1, dvalid=1.
- err=0 on all in-range results.

Back-to-back hazard:
- A read of an address written on the previous accept returns the updated word, in both modes.

Width rules:
- Addresses are unsigned.
- No parity or ECC.

Test Plan:
1. Reset then fill: rsta=1 for 2 cycles, release. busy stays high for exactly DEPTH (3072) cycles. Then read addr 0, 1535 and 3071; each returns 0x00000000 with dvalid=1 and err=0 after RD_LAT.
2. Byte lanes: write 0xAABBCCDD with wea=4'hF to addr 5, then wea=4'b0100 with dina=0x00EE0000. Reading addr 5 returns 0xAAEECCDD. Then wea=4'b1010 with dina=0x11223344 gives 0x11EE33DD.
3. Read-during-write: word 7 holds 0x12345678; write 0xFFFFFFFF with wea=4'hF. WRITE_MODE=0 returns 0x12345678 on that access; WRITE_MODE=1 returns 0xFFFFFFFF. The next read returns 0xFFFFFFFF in both modes.
4. Latency/streaming: with RD_LAT=2, issue 4 consecutive reads of addr 0..3 (preloaded 1,2,3,4). dvalid is high for 4 consecutive cycles starting 2 cycles after the first request, and data is 1,2,3,4 in order.
5. Out of range: write 0xDEADBEEF to addr 3072 (ADDR_W=12). The response has err=1, dvalid=1, douta=0. Word 0 and word 3071 are unchanged.
6. Reset mid-fill and mid-read:
   - Assert rsta at fill cycle 100. busy stays high for a further full 3072 cycles after release.
   - Assert rsta one cycle after a RD_LAT=2 read. No dvalid is produced for that read.
